// File: rtl/dvsd_pd_evt.sv
// Consumer-side decoder for the dvsd_pe priority-encoder interface: stability-filtered
// event capture into a sticky pending register, drained highest-index first over valid/ready.
module dvsd_pd_evt #(
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [2:0] in_code,
  input  logic       in_gs,
  input  logic       in_eno,
  output logic [7:0] out_onehot,
  output logic [7:0] pend,
  output logic       ovf,
  output logic       idle_seen,
  output logic       evt_valid,
  output logic [2:0] evt_code,
  input  logic       evt_ready
);

  localparam logic [3:0] StableCnt = 4'(STABLE_CYCLES);

  typedef enum logic {StIdle, StPresent} state_e;

  state_e     state_q, state_d;
  logic [2:0] s_code_q, s_code_d;
  logic [3:0] run_q, run_d;
  logic [7:0] onehot_q, onehot_d;
  logic [7:0] pend_q, pend_d;
  logic       ovf_q, ovf_d;
  logic       idle_q, idle_d;
  logic       valid_q, valid_d;
  logic [2:0] code_q, code_d;

  logic       req;
  logic       run_start;
  logic       accept;
  logic       clr;
  logic [2:0] hi_idx;

  // Stability filter: a code change restarts the run at 1, so acceptance fires only when the
  // run first reaches StableCnt (or on the restart edge itself when StableCnt is 1).
  always_comb begin
    req       = en & in_gs;
    run_start = req & ((run_q == 4'd0) | (in_code != s_code_q));
    if (!req) begin
      run_d = 4'd0;
    end else if (run_start) begin
      run_d = 4'd1;
    end else if (run_q >= StableCnt) begin
      run_d = StableCnt;
    end else begin
      run_d = run_q + 4'd1;
    end
    accept   = req & (run_d == StableCnt) & (run_start | (run_q != StableCnt));
    s_code_d = in_code;
    onehot_d = req ? (8'b1 << in_code) : 8'h00;
    idle_d   = en & in_eno & ~in_gs;
  end

  always_comb begin
    hi_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pend_q[i]) hi_idx = 3'(i);
    end
  end

  // Clear is applied before set so a same-index accept on the handshake edge keeps the bit.
  always_comb begin
    clr    = (state_q == StPresent) & evt_ready;
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (clr) pend_d[code_q] = 1'b0;
    if (accept) begin
      if (pend_q[in_code] && !(clr && (code_q == in_code))) ovf_d = 1'b1;
      pend_d[in_code] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    code_d  = code_q;
    unique case (state_q)
      StIdle: begin
        if (pend_q != 8'h00) begin
          state_d = StPresent;
          valid_d = 1'b1;
          code_d  = hi_idx;
        end
      end
      StPresent: begin
        if (evt_ready) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      s_code_q <= 3'd0;
      run_q    <= 4'd0;
      onehot_q <= 8'h00;
      pend_q   <= 8'h00;
      ovf_q    <= 1'b0;
      idle_q   <= 1'b0;
      valid_q  <= 1'b0;
      code_q   <= 3'd0;
    end else begin
      state_q  <= state_d;
      s_code_q <= s_code_d;
      run_q    <= run_d;
      onehot_q <= onehot_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      idle_q   <= idle_d;
      valid_q  <= valid_d;
      code_q   <= code_d;
    end
  end

  assign out_onehot = onehot_q;
  assign pend       = pend_q;
  assign ovf        = ovf_q;
  assign idle_seen  = idle_q;
  assign evt_valid  = valid_q;
  assign evt_code   = code_q;

endmodule

// File: tb/tb_dvsd_pd_evt.sv
// Bench for dvsd_pd_evt: directed scenarios plus random traffic, checked against a
// behavioural model with a queue of expected event presentations.
module tb_dvsd_pd_evt;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [2:0] in_code;
  logic       in_gs;
  logic       in_eno;
  logic [7:0] out_onehot;
  logic [7:0] pend;
  logic       ovf;
  logic       idle_seen;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic       evt_ready;

  dvsd_pd_evt #(.STABLE_CYCLES(S)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .in_code    (in_code),
    .in_gs      (in_gs),
    .in_eno     (in_eno),
    .out_onehot (out_onehot),
    .pend       (pend),
    .ovf        (ovf),
    .idle_seen  (idle_seen),
    .evt_valid  (evt_valid),
    .evt_code   (evt_code),
    .evt_ready  (evt_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 0;

  // Reference model state
  bit m_pend[8];
  bit m_ovf;
  int m_onehot;
  bit m_idle;
  int m_run;
  int m_scode;
  bit m_present;
  int m_code;
  int exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_pend_vec();
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = m_pend[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_pend[i] = 0;
    m_ovf = 0; m_onehot = 0; m_idle = 0; m_run = 0; m_scode = 0;
    m_present = 0; m_code = 0;
  endtask

  // One clock edge of behaviour, computed from the inputs applied before that edge.
  task automatic model_step();
    int  code, new_run, hi;
    bit  req, start, accept, clr, any, old_bit;
    if (reset) begin
      model_reset();
      return;
    end
    code    = int'(in_code);
    req     = en && in_gs;
    start   = req && (m_run == 0 || code != m_scode);
    new_run = !req ? 0 : (start ? 1 : ((m_run + 1 > S) ? S : m_run + 1));
    accept  = req && (new_run == S) && (start || m_run != S);
    clr     = m_present && evt_ready;
    any = 0;
    hi  = 0;
    for (int i = 0; i < 8; i++) if (m_pend[i]) begin any = 1; hi = i; end
    old_bit = m_pend[code];
    if (clr) m_pend[m_code] = 0;
    if (accept) begin
      if (old_bit && !(clr && m_code == code)) m_ovf = 1;
      m_pend[code] = 1;
    end
    if (m_present) begin
      if (evt_ready) m_present = 0;
    end else if (any) begin
      m_present = 1;
      m_code    = hi;
      exp_q.push_back(hi);
    end
    m_onehot = req ? (1 << code) : 0;
    m_scode  = code;
    m_run    = new_run;
    m_idle   = en && in_eno && !in_gs;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic put(input bit e, input int c, input bit g, input bit r);
    en        = e;
    in_code   = 3'(c);
    in_gs     = g;
    evt_ready = r;
    in_eno    = 1'($urandom % 2);
  endtask

  // Monitor: per-cycle state compare, and pops an expected code on each new presentation.
  initial begin
    bit last_valid = 0;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("pend", pend, m_pend_vec());
        check("ovf", ovf, m_ovf);
        check("out_onehot", out_onehot, m_onehot);
        check("idle_seen", idle_seen, m_idle);
        check("evt_valid", evt_valid, m_present);
        if (evt_valid && !last_valid) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL evt_unexpected: got code %0d expected no event", evt_code);
          end else begin
            check("evt_order", evt_code, exp_q.pop_front());
          end
        end
        last_valid = evt_valid;
      end
    end
  end

  initial begin
    reset = 1'b1;
    put(0, 0, 0, 0);
    cyc(2);
    reset  = 1'b0;
    chk_en = 1;

    // Walk all codes with the consumer always ready
    for (int c = 0; c < 8; c++) begin
      put(1, c, 1, 1);
      cyc(10);
      check("t1_onehot", out_onehot, 32'(1 << c));
    end
    put(1, 0, 0, 1);
    cyc(4);
    check("t1_ovf", ovf, 0);
    check("t1_pend", pend, 8'h00);

    // Glitch rejection
    put(1, 0, 0, 0); cyc(3);
    put(1, 3, 1, 0); cyc(1);
    put(1, 6, 1, 0); cyc(3);
    put(1, 0, 0, 0); cyc(1);
    check("t2_pend", pend, 8'h40);
    put(1, 0, 0, 1); cyc(4);

    // Priority drain order behind a held presentation of code 0
    put(1, 0, 1, 0); cyc(2); put(1, 0, 0, 0); cyc(1);
    put(1, 2, 1, 0); cyc(2); put(1, 0, 0, 0); cyc(1);
    put(1, 7, 1, 0); cyc(2); put(1, 0, 0, 0); cyc(1);
    put(1, 5, 1, 0); cyc(2); put(1, 0, 0, 0); cyc(1);
    check("t3_pend", pend, 8'hA5);
    check("t3_code", evt_code, 0);
    put(1, 0, 0, 1); cyc(10);
    check("t3_drained", pend, 8'h00);

    // Overflow
    put(1, 4, 1, 0); cyc(2); put(1, 0, 0, 0); cyc(1);
    put(1, 4, 1, 0); cyc(2); put(1, 0, 0, 0); cyc(1);
    check("t4_ovf", ovf, 1);
    check("t4_pend", pend, 8'h10);
    put(1, 0, 0, 1); cyc(4);
    check("t4_drained", pend, 8'h00);
    reset = 1'b1; cyc(1); reset = 1'b0;

    // Set/clear collision on code 1
    put(1, 1, 1, 0); cyc(2); put(1, 0, 0, 0); cyc(1);
    put(1, 1, 1, 0); cyc(1);
    put(1, 1, 1, 1); cyc(1);
    put(1, 0, 0, 0); cyc(1);
    check("t5_pend", pend, 8'h02);
    check("t5_ovf", ovf, 0);
    check("t5_valid", evt_valid, 1);
    put(1, 0, 0, 1); cyc(4);

    // Reset in the middle of a presentation
    put(1, 0, 1, 0); cyc(2);
    put(1, 7, 1, 0); cyc(2);
    put(1, 0, 0, 0); cyc(1);
    check("t6_pend_pre", pend, 8'h81);
    check("t6_valid_pre", evt_valid, 1);
    reset = 1'b1; cyc(1); reset = 1'b0;
    check("t6_pend", pend, 8'h00);
    check("t6_valid", evt_valid, 0);
    check("t6_onehot", out_onehot, 8'h00);
    check("t6_ovf", ovf, 0);
    put(0, 5, 1, 0); cyc(5);
    check("t6_disabled", pend, 8'h00);

    // Random traffic
    for (int k = 0; k < 150; k++) begin
      int c, len;
      bit g, e;
      c   = int'($urandom % 8);
      len = 1 + int'($urandom % 4);
      g   = ($urandom % 6) != 0;
      e   = ($urandom % 8) != 0;
      repeat (len) begin
        put(e, c, g, 1'($urandom % 2));
        cyc(1);
      end
    end
    put(1, 0, 0, 1);
    cyc(30);
    check("end_queue_empty", exp_q.size(), 0);
    check("end_pend", pend, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
